truth_table_sweeper: RTL and testbench

Parametrised, self-checking exhaustive stimulus engine for small combinational lab circuits. It replaces hand-written per-circuit vector lists. On start, it drives every N_IN-bit input combination in ascending order and holds each one for HOLD cycles. It samples the DUT response at the end of each hold, compares it against a golden truth table parameter, and reports pass/fail, error count and first failing vector. It sits between the DUT and the bench, and can also be synthesised as an on-board BIST driver.

---
 rtl/truth_table_sweeper_pkg.sv | 14 +
 rtl/truth_table_sweeper_hold_timer.sv | 28 ++
 rtl/truth_table_sweeper.sv | 102 ++++++++++
 tb/tb_truth_table_sweeper.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// tts_pkg: shared state encoding and sizing helpers for the truth table sweeper
package tts_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int cnt_w(input int hold);
        return $clog2(hold);
    endfunction

    function automatic int nvec(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// hold_timer: modulo-HOLD counter with synchronous clear and terminal-count flag
module hold_timer
    import tts_pkg::*;
#(
    parameter int HOLD = 20,
    parameter int W    = cnt_w(HOLD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = cnt == W'(HOLD - 1);

    // count up while enabled, wrapping at HOLD-1; clear wins over enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive stimulus sweep with golden-table response checking
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int                            N_IN     = 3,
    parameter int                            N_OUT    = 1,
    parameter int                            HOLD     = 20,
    parameter logic [N_OUT*(1<<N_IN)-1:0]    EXPECTED = 8'hE8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [N_OUT-1:0]  dut_y,
    output logic [N_IN-1:0]   stim,
    output logic              sample_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_cnt,
    output logic [N_IN-1:0]   first_fail,
    output logic              first_fail_vld
);

    localparam int              CW   = cnt_w(HOLD);
    localparam logic [N_IN-1:0] LAST = N_IN'(nvec(N_IN) - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   hold_cnt;
    logic            tc;
    logic            run, go, sample, last, miss;

    assign run       = state == RUN;
    assign go        = !run && start && !abort;
    assign sample    = run && tc && !abort;
    assign last      = stim == LAST;
    assign miss      = dut_y != EXPECTED[stim*N_OUT +: N_OUT];
    assign sample_en = run && hold_cnt == CW'(HOLD - 1);

    hold_timer #(.HOLD(HOLD), .W(CW)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (!run || abort),
        .en  (run),
        .cnt (hold_cnt),
        .tc  (tc)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next state: start from IDLE/DONE, abort out of RUN, terminal sample into DONE
    always_comb begin
        state_nxt = go ? RUN : (run && abort) ? IDLE : (sample && last) ? DONE : state;
    end

    // stimulus index, status flags and error bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stim           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (go) begin
            stim           <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (run && abort) begin
            stim <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (sample) begin
            if (miss) begin
                err_cnt <= err_cnt + 1'b1;
                if (!first_fail_vld) begin
                    first_fail     <= stim;
                    first_fail_vld <= 1'b1;
                end
            end
            if (last) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= err_cnt == '0 && !miss;
            end else begin
                stim <= stim + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed checks of the sweeper against behavioural lab DUTs
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [0:0]  dut_y;
    logic [2:0]  stim;
    logic        sample_en, busy, done, pass, first_fail_vld;
    logic [3:0]  err_cnt;
    logic [2:0]  first_fail;

    logic        start4 = 1'b0, abort4 = 1'b0;
    logic [1:0]  dut_y4;
    logic [3:0]  stim4;
    logic        sample_en4, busy4, done4, pass4, first_fail_vld4;
    logic [4:0]  err_cnt4;
    logic [3:0]  first_fail4;

    int mode = 0;
    logic fault4 = 1'b0;
    int t = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    truth_table_sweeper u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .dut_y          (dut_y),
        .stim           (stim),
        .sample_en      (sample_en),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_fail     (first_fail),
        .first_fail_vld (first_fail_vld)
    );

    truth_table_sweeper #(.N_IN(4), .N_OUT(2), .HOLD(2), .EXPECTED(32'h934E39E4)) u_dut4 (
        .clk            (clk),
        .rst            (rst),
        .start          (start4),
        .abort          (abort4),
        .dut_y          (dut_y4),
        .stim           (stim4),
        .sample_en      (sample_en4),
        .busy           (busy4),
        .done           (done4),
        .pass           (pass4),
        .err_cnt        (err_cnt4),
        .first_fail     (first_fail4),
        .first_fail_vld (first_fail_vld4)
    );

    // lab circuits: 3-input majority variants and a 2-bit adder truncated to 2 bits
    always_comb begin
        logic maj;
        logic [1:0] s;
        maj = (stim[2] & stim[1]) | (stim[2] & stim[0]) | (stim[1] & stim[0]);
        dut_y[0] = mode == 1 ? ~maj : (mode == 2 && stim == 3'd5) ? 1'b0 : maj;
        s = stim4[3:2] + stim4[1:0];
        dut_y4 = (fault4 && stim4 == 4'd9) ? s ^ 2'b01 : s;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic goto(input int e);
        while (t < e) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic go1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t = 0;
    endtask

    task automatic go4;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        t = 0;
    endtask

    initial begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stim", stim, 0);
        check("rst_err", err_cnt, 0);
        check("rst_ffv", first_fail_vld, 0);
        check("rst_pass", pass, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // clean majority sweep, with a start pulse while busy at edge 30
        mode = 0;
        go1;
        check("t1_busy0", busy, 1);
        check("t1_stim0", stim, 0);
        goto(19);
        check("t1_sen19", sample_en, 1);
        check("t1_stim19", stim, 0);
        goto(20);
        check("t1_stim20", stim, 1);
        check("t1_sen20", sample_en, 0);
        goto(29);
        start = 1'b1;
        goto(30);
        start = 1'b0;
        goto(39);
        check("t1_stim39", stim, 1);
        goto(40);
        check("t1_stim40", stim, 2);
        goto(159);
        check("t1_stim159", stim, 7);
        check("t1_done159", done, 0);
        goto(160);
        check("t1_done", done, 1);
        check("t1_busy", busy, 0);
        check("t1_pass", pass, 1);
        check("t1_err", err_cnt, 0);
        check("t1_ffv", first_fail_vld, 0);
        check("t1_stim_hold", stim, 7);

        // inverted majority: every vector fails
        mode = 1;
        go1;
        goto(160);
        check("t2_err", err_cnt, 8);
        check("t2_ff", first_fail, 0);
        check("t2_ffv", first_fail_vld, 1);
        check("t2_pass", pass, 0);

        // single fault at vector 5; restart from DONE clears the previous count
        mode = 2;
        go1;
        check("t3_err_clr", err_cnt, 0);
        check("t3_ffv_clr", first_fail_vld, 0);
        goto(160);
        check("t3_err", err_cnt, 1);
        check("t3_ff", first_fail, 5);
        check("t3_ffv", first_fail_vld, 1);
        check("t3_pass", pass, 0);

        // abort during vector 2 keeps partial errors
        mode = 1;
        go1;
        goto(49);
        abort = 1'b1;
        goto(50);
        abort = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_stim", stim, 0);
        check("t4_done", done, 0);
        check("t4_err", err_cnt, 2);
        check("t4_ffv", first_fail_vld, 1);
        goto(53);
        check("t4_idle_stim", stim, 0);

        // abort coincident with a sample edge discards that sample
        go1;
        goto(59);
        abort = 1'b1;
        goto(60);
        abort = 1'b0;
        check("t4b_err", err_cnt, 2);
        check("t4b_busy", busy, 0);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        goto(61);
        start = 1'b0;
        abort = 1'b0;
        check("t4c_busy", busy, 0);
        check("t4c_err", err_cnt, 2);

        // subsequent clean sweep
        mode = 0;
        go1;
        goto(160);
        check("t4d_done", done, 1);
        check("t4d_pass", pass, 1);
        check("t4d_err", err_cnt, 0);

        // asynchronous reset mid-cycle during vector 4
        mode = 1;
        go1;
        goto(85);
        check("t5_pre_err", err_cnt, 4);
        check("t5_pre_stim", stim, 4);
        #3;
        rst = 1'b1;
        #1;
        check("t5_busy", busy, 0);
        check("t5_stim", stim, 0);
        check("t5_err", err_cnt, 0);
        check("t5_ffv", first_fail_vld, 0);
        check("t5_sen", sample_en, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t5_post_busy", busy, 0);

        // 4-input adder table, HOLD=2
        fault4 = 1'b0;
        go4;
        goto(31);
        check("t6_done31", done4, 0);
        check("t6_stim31", stim4, 15);
        goto(32);
        check("t6_done", done4, 1);
        check("t6_pass", pass4, 1);
        check("t6_err", err_cnt4, 0);

        fault4 = 1'b1;
        go4;
        goto(32);
        check("t6f_err", err_cnt4, 1);
        check("t6f_ff", first_fail4, 9);
        check("t6f_pass", pass4, 0);

        fault4 = 1'b0;
        go4;
        check("t6r_err_clr", err_cnt4, 0);
        check("t6r_busy", busy4, 1);
        check("t6r_done", done4, 0);
        goto(32);
        check("t6r_pass", pass4, 1);
        check("t6r_done2", done4, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
